// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the parametrised FIFO:
//               a width function for pointers and occupancy counts,
//               default configuration values and the default pointer type.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_AE_TH = 2;

  // Ceiling log2 with a floor of one bit, usable in constant expressions.
  // A count that must hold the value N needs fifo_clog2(N+1) bits.
  function automatic int unsigned fifo_clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned p = 1; p < value; p = p << 1) w = w + 1;
    return (w == 0) ? 1 : w;
  endfunction

  // Default almost-full threshold: two entries below completely full.
  function automatic int unsigned def_af_th(input int unsigned depth);
    return depth - 2;
  endfunction

  // Pointer type of the default-depth configuration.
  typedef logic [fifo_clog2(DEF_DEPTH)-1:0] def_ptr_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrap-around index counter for the FIFO storage array.
//               Counts 0..DEPTH-1 and wraps to 0; DEPTH need not be a
//               power of two.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-low reset (pointer -> 0)
//               inc   - advance the pointer by one entry
//               ptr   - current index
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned PW    = fifo_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      // Explicit wrap so non-power-of-two depths never index past the end.
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO with simultaneous read/write,
//               occupancy count, almost-full/almost-empty flags and
//               one-cycle overflow/underflow pulses.
//               Build option FIFO_FWFT_EN: first-word-fall-through, dataOut
//               shows the head entry combinationally whenever not empty.
//               Without it dataOut is registered with one cycle of latency.
// Ports       : clk         - clock, rising edge
//               reset       - asynchronous active-low reset
//               write       - write request, dataIn - write data
//               read        - read request,  dataOut - read data
//               full/empty  - count == DEPTH / count == 0
//               almostFull  - count >= AF_TH
//               almostEmpty - count <= AE_TH
//               count       - occupancy
//               overflow    - pulse: write request rejected
//               underflow   - pulse: read request rejected
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned AF_TH = def_af_th(DEPTH),
  parameter  int unsigned AE_TH = DEF_AE_TH,
  localparam int unsigned CW    = fifo_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             read,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty,
  output logic             almostFull,
  output logic             almostEmpty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = fifo_clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [CW-1:0]    count_next;

  // A write into a full FIFO is still accepted when a read frees a slot
  // on the same edge.
  assign rd_acc     = read & ~empty;
  assign wr_acc     = write & (~full | rd_acc);
  assign count_next = count + CW'(wr_acc) - CW'(rd_acc);

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; a write attempted during reset lands
  // at a pointer that cannot advance and is overwritten later.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= dataIn;
  end

  // Flags are registered from count_next so they line up with count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almostFull  <= (AF_TH == 0);
      almostEmpty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      count       <= count_next;
      full        <= (count_next == CW'(DEPTH));
      empty       <= (count_next == '0);
      almostFull  <= (32'(count_next) >= AF_TH);
      almostEmpty <= (32'(count_next) <= AE_TH);
      overflow    <= write & ~wr_acc;
      underflow   <= read & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is always presented; read only acknowledges it.
  assign dataOut = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut <= '0;
    end else if (rd_acc) begin
      dataOut <= mem[rd_ptr];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Self-checking bench for fifo_sync_param. A DEPTH=8 instance
//               runs a table of vectors; a DEPTH=5 instance covers pointer
//               wrap and asynchronous reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic        rst8_n, wr8, rd8;
  logic [15:0] din8, dout8;
  logic        full8, empty8, af8, ae8, ovf8, udf8;
  logic [3:0]  cnt8;

  // DEPTH=5 instance
  logic        rst5_n, wr5, rd5;
  logic [15:0] din5, dout5;
  logic        full5, empty5, af5, ae5, ovf5, udf5;
  logic [2:0]  cnt5;

  fifo_sync_param #(.WIDTH(16), .DEPTH(8)) u8 (
    .clk(clk), .reset(rst8_n), .write(wr8), .dataIn(din8), .read(rd8),
    .dataOut(dout8), .full(full8), .empty(empty8), .almostFull(af8),
    .almostEmpty(ae8), .count(cnt8), .overflow(ovf8), .underflow(udf8)
  );

  fifo_sync_param #(.WIDTH(16), .DEPTH(5)) u5 (
    .clk(clk), .reset(rst5_n), .write(wr5), .dataIn(din5), .read(rd5),
    .dataOut(dout5), .full(full5), .empty(empty5), .almostFull(af5),
    .almostEmpty(ae5), .count(cnt5), .overflow(ovf5), .underflow(udf5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] din;
    int          cnt;
    bit          ovf;
    bit          udf;
  } vec_t;

  function automatic vec_t mk(bit wr, bit rd, logic [15:0] din, int cnt, bit ovf, bit udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  vec_t        vecs[$];
  logic [15:0] sb8[$];
  logic [15:0] sb5[$];
  logic [15:0] exp_dout8;
  logic [15:0] exp_dout5;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---------------- vector table (DEPTH=8, AF_TH=6, AE_TH=2) -----------
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b1, 1'b0, 16'(i), i, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0009, 8, 1'b1, 1'b0));            // overflow
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b0, 1'b1, 16'h0, 8 - i, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 16'h0, 0, 1'b0, 1'b1));               // underflow
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b1, 1'b0, 16'(16'h0010 + i), i, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 16'hAAAA, 8, 1'b0, 1'b0));            // full, rd+wr
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b0, 1'b1, 16'h0, 8 - i, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 16'h1234, 1, 1'b0, 1'b1));            // empty, rd+wr
    vecs.push_back(mk(1'b0, 1'b1, 16'h0, 0, 1'b0, 1'b0));               // returns 0x1234

    // ---------------- reset ----------------------------------------------
    rst8_n = 1'b0; wr8 = 1'b0; rd8 = 1'b0; din8 = '0;
    rst5_n = 1'b0; wr5 = 1'b0; rd5 = 1'b0; din5 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(cnt8), 0);
    check("rst_empty", 32'(empty8), 1);
    check("rst_full", 32'(full8), 0);
    check("rst_af", 32'(af8), 0);
    check("rst_ae", 32'(ae8), 1);
    check("rst_ovf", 32'(ovf8), 0);
    check("rst_udf", 32'(udf8), 0);
`ifndef FIFO_FWFT_EN
    check("rst_dout", 32'(dout8), 0);
`endif
    check("rst5_count", 32'(cnt5), 0);
    rst8_n = 1'b1;
    rst5_n = 1'b1;
    exp_dout8 = '0;

    // ---------------- table-driven run with scoreboard -------------------
    foreach (vecs[n]) begin
      bit rd_ok, wr_ok;
      wr8 = vecs[n].wr; rd8 = vecs[n].rd; din8 = vecs[n].din;
      rd_ok = vecs[n].rd && (sb8.size() > 0);
      wr_ok = vecs[n].wr && ((sb8.size() < 8) || rd_ok);
      if (rd_ok) exp_dout8 = sb8.pop_front();
      if (wr_ok) sb8.push_back(vecs[n].din);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", n), 32'(cnt8), 32'(vecs[n].cnt));
      check($sformatf("v%0d_full", n), 32'(full8), 32'(vecs[n].cnt == 8));
      check($sformatf("v%0d_empty", n), 32'(empty8), 32'(vecs[n].cnt == 0));
      check($sformatf("v%0d_af", n), 32'(af8), 32'(vecs[n].cnt >= 6));
      check($sformatf("v%0d_ae", n), 32'(ae8), 32'(vecs[n].cnt <= 2));
      check($sformatf("v%0d_ovf", n), 32'(ovf8), 32'(vecs[n].ovf));
      check($sformatf("v%0d_udf", n), 32'(udf8), 32'(vecs[n].udf));
`ifdef FIFO_FWFT_EN
      if (sb8.size() > 0) check($sformatf("v%0d_dout", n), 32'(dout8), 32'(sb8[0]));
`else
      check($sformatf("v%0d_dout", n), 32'(dout8), 32'(exp_dout8));
`endif
    end
    wr8 = 1'b0; rd8 = 1'b0;

`ifdef FIFO_FWFT_EN
    // ---------------- first-word-fall-through ----------------------------
    wr8 = 1'b1; din8 = 16'h00FF;
    @(posedge clk); #1;
    wr8 = 1'b0;
    check("fwft_empty", 32'(empty8), 0);
    check("fwft_dout", 32'(dout8), 32'h00FF);
    rd8 = 1'b1;
    @(posedge clk); #1;
    rd8 = 1'b0;
    check("fwft_pop_empty", 32'(empty8), 1);
`endif

    // ---------------- DEPTH=5: wrap under continuous traffic -------------
    exp_dout5 = '0;
    for (int k = 0; k < 23; k++) begin
      bit rd_ok, wr_ok;
      wr5 = 1'b1; din5 = 16'(16'h0100 + k); rd5 = (k >= 3);
      rd_ok = rd5 && (sb5.size() > 0);
      wr_ok = (sb5.size() < 5) || rd_ok;
      if (rd_ok) exp_dout5 = sb5.pop_front();
      if (wr_ok) sb5.push_back(din5);
      @(posedge clk);
      #1;
      if (k >= 3) begin
        check($sformatf("w%0d_count", k), 32'(cnt5), 3);
        check($sformatf("w%0d_af", k), 32'(af5), 1);
`ifdef FIFO_FWFT_EN
        check($sformatf("w%0d_dout", k), 32'(dout5), 32'(sb5[0]));
`else
        check($sformatf("w%0d_dout", k), 32'(dout5), 32'(exp_dout5));
`endif
      end
    end
    wr5 = 1'b0; rd5 = 1'b0;

    // ---------------- asynchronous reset mid-stream ----------------------
    #3;
    rst5_n = 1'b0;
    #1;
    check("arst_count", 32'(cnt5), 0);
    check("arst_empty", 32'(empty5), 1);
    check("arst_ae", 32'(ae5), 1);
    check("arst_af", 32'(af5), 0);
`ifndef FIFO_FWFT_EN
    check("arst_dout", 32'(dout5), 0);
`endif
    sb5.delete();
    wr5 = 1'b1; din5 = 16'hDEAD;                  // ignored while in reset
    @(posedge clk); #1;
    check("arst_ignored", 32'(cnt5), 0);
    wr5 = 1'b0;
    rst5_n = 1'b1;
    wr5 = 1'b1; din5 = 16'h0BEE;
    @(posedge clk); #1;
    wr5 = 1'b0; rd5 = 1'b1;
    check("resume_count", 32'(cnt5), 1);
    @(posedge clk); #1;
    rd5 = 1'b0;
    check("resume_empty", 32'(empty5), 1);
`ifndef FIFO_FWFT_EN
    check("resume_dout", 32'(dout5), 32'h0BEE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
